// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int HALF = 16;
  localparam logic [1:0] RVC_OP_LO = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

  function automatic logic is_rvc(input logic [HALF-1:0] h);
    return h[1:0] != RVC_OP_LO;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry word queue with flush; exposes head, head+1 and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output fetch_entry_t             head_nxt,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge gclk)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge gclk) begin
    if (!grst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + AW'(1)];
endmodule

// File: rtl/fetch_align_queue.sv
// Fetch front end: sequential word fetch, queueing and 16/32-bit realignment.
// Define FETCH_COMPRESSED_EN to enable halfword (compressed) realignment.
module fetch_align_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDRESS,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_READDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [ILEN-1:0] INSTR_RAW,
  output logic [XLEN-1:0] INSTR_PC,
  output logic            INSTR_COMPRESSED
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   outstanding, stale, occ;
  logic            in_rst, fire, rsp, consume, pop, valid, comp, offset;
  logic [ILEN-1:0] raw;
  fetch_entry_t    head, head_nxt;

  assign IMEM_REQ     = !in_rst && (({1'b0, occ} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign IMEM_ADDRESS = fetch_pc;
  assign fire         = IMEM_REQ && IMEM_GNT;
  // Any response with nothing outstanding predates the last reset and is ignored.
  assign rsp          = IMEM_RVALID && (outstanding != '0);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .gclk      (CLK),
    .grst_n    (RESET),
    .flush     (REDIRECT),
    .push      (rsp && (stale == '0)),
    .push_data ('{word: IMEM_READDATA, addr: rsp_pc}),
    .pop       (pop),
    .head      (head),
    .head_nxt  (head_nxt),
    .count     (occ)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      in_rst      <= 1'b1;
    end else begin
      in_rst      <= 1'b0;
      outstanding <= outstanding + CW'(fire) - CW'(rsp);
      if (REDIRECT) begin
        stale    <= outstanding + CW'(fire) - CW'(rsp);
        fetch_pc <= {REDIRECT_PC[XLEN-1:2], 2'b00};
        rsp_pc   <= {REDIRECT_PC[XLEN-1:2], 2'b00};
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && stale != '0) stale <= stale - CW'(1);
        else if (rsp)           rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_COMPRESSED_EN
  logic [HALF-1:0] half;

  always_comb begin
    half  = offset ? head.word[31:16] : head.word[15:0];
    comp  = is_rvc(half);
    // A 32-bit instruction starting in the upper half needs the next word queued.
    valid = !in_rst && (occ != '0) && (comp || !offset || occ >= CW'(2));
    if (comp)        raw = {{(ILEN-HALF){1'b0}}, half};
    else if (offset) raw = {head_nxt.word[HALF-1:0], half};
    else             raw = head.word;
  end

  assign pop = consume && (!comp || offset);

  always_ff @(posedge CLK) begin
    if (!RESET)        offset <= 1'b0;
    else if (REDIRECT) offset <= REDIRECT_PC[1];
    else if (consume)  offset <= comp ? !offset : offset;
  end
`else
  assign offset = 1'b0;

  always_comb begin
    valid = !in_rst && (occ != '0);
    raw   = head.word;
    comp  = 1'b0;
  end

  assign pop = consume;
`endif

  assign consume          = valid && INSTR_READY;
  assign INSTR_VALID      = valid;
  assign INSTR_RAW        = raw;
  assign INSTR_COMPRESSED = comp;
  assign INSTR_PC         = {head.addr[XLEN-1:2], offset, 1'b0};

  logic unused_bits;
  assign unused_bits = ^{REDIRECT_PC[1:0], head.addr[1:0], head_nxt};
endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed + randomized bench for fetch_align_queue against an instruction-stream model.
module tb_fetch_align_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        CLK, RESET, IMEM_REQ, IMEM_GNT, IMEM_RVALID, REDIRECT;
  logic        INSTR_VALID, INSTR_READY, INSTR_COMPRESSED;
  logic [31:0] IMEM_ADDRESS, IMEM_READDATA, REDIRECT_PC, INSTR_RAW, INSTR_PC;

  fetch_align_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDRESS(IMEM_ADDRESS),
    .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_READDATA(IMEM_READDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .INSTR_RAW(INSTR_RAW), .INSTR_PC(INSTR_PC),
    .INSTR_COMPRESSED(INSTR_COMPRESSED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int rdy; } pend_t;

  int          n_assert = 0, n_fail = 0, cyc = 0, n_fire = 0, early_cnt = 0;
  int          lat = 1, slow_extra = 0, rdy_mode = 1;
  bit          lat_rand = 0, gnt_rand = 0, straddle_on = 0, w1_seen = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF, seed = 32'h1234_5678;
  logic [31:0] pc_m = RESET_PC, exp_fetch = RESET_PC;
  logic [31:0] mem [logic [31:0]];
  pend_t       pend[$];
  logic [31:0] cons_pc[$], cons_raw[$];
  int          cons_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] p);
    logic [31:0] w;
    w = word_at({p[31:2], 2'b00});
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic clear_log();
    cons_pc.delete(); cons_raw.delete(); cons_cyc.delete();
  endtask

  // One clock: check at the current negedge, advance memory/model after the edge.
  task automatic tick();
    logic        fire, rv, cons, ec;
    logic [31:0] a, er;
    int          st;
`ifdef FETCH_COMPRESSED_EN
    logic [15:0] h;
`endif
    cyc++;
    fire = (IMEM_REQ === 1'b1) && (IMEM_GNT === 1'b1);
    rv   = IMEM_RVALID;
    a    = IMEM_ADDRESS;
    if (fire) n_fire++;
    if (fire && RESET) chk("fetch_addr", IMEM_ADDRESS, exp_fetch);
    if (straddle_on && INSTR_VALID === 1'b1 && INSTR_PC == 32'h2 && !w1_seen) early_cnt++;
    cons = RESET && !REDIRECT && (INSTR_VALID === 1'b1) && INSTR_READY;
    if (cons) begin
`ifdef FETCH_COMPRESSED_EN
      h = half_at(pc_m);
      if (h[1:0] != 2'b11) begin er = {16'h0, h}; ec = 1'b1; st = 2; end
      else begin er = {half_at(pc_m + 32'd2), h}; ec = 1'b0; st = 4; end
`else
      er = word_at(pc_m); ec = 1'b0; st = 4;
`endif
      chk("instr_pc", INSTR_PC, pc_m);
      chk("instr_raw", INSTR_RAW, er);
      chk("instr_compressed", {31'b0, INSTR_COMPRESSED}, {31'b0, ec});
      cons_pc.push_back(INSTR_PC); cons_raw.push_back(INSTR_RAW); cons_cyc.push_back(cyc);
      pc_m = pc_m + 32'(st);
    end
    @(posedge CLK); #1;
    if (rv && pend.size() > 0) begin
      if (pend[0].addr == 32'h4) w1_seen = 1;
      void'(pend.pop_front());
    end
    if (fire) begin
      pend.push_back('{addr: a, rdy: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat)
                                    + ((a == slow_addr) ? slow_extra : 0)});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (REDIRECT) begin
      exp_fetch = {REDIRECT_PC[31:2], 2'b00};
`ifdef FETCH_COMPRESSED_EN
      pc_m = {REDIRECT_PC[31:1], 1'b0};
`else
      pc_m = exp_fetch;
`endif
    end
    if (!RESET) begin
      pend.delete(); exp_fetch = RESET_PC; pc_m = RESET_PC;
    end
    REDIRECT      = 1'b0;
    IMEM_RVALID   = (pend.size() > 0) && (pend[0].rdy <= cyc + 1);
    IMEM_READDATA = IMEM_RVALID ? word_at(pend[0].addr) : 32'h0;
    IMEM_GNT      = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    INSTR_READY   = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (2) begin
      tick();
      chk("reset_req", {31'b0, IMEM_REQ}, 32'h0);
      chk("reset_valid", {31'b0, INSTR_VALID}, 32'h0);
    end
  endtask

  task automatic run_until_cons(input int n, input int budget, input string tag);
    int k = 0;
    while (cons_pc.size() < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(cons_pc.size()), 32'(n));
  endtask

  initial begin
    int t0, n0;
    RESET = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_READDATA = 32'h0;
    REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INSTR_READY = 1'b1;
    @(negedge CLK);

    // Two plain 32-bit instructions, single-cycle memory
    mem.delete(); mem[32'h0] = 32'h0050_0093; mem[32'h4] = 32'h00A0_0113;
    do_reset(); clear_log(); t0 = cyc; RESET = 1'b1;
    run_until_cons(2, 20, "t1_count");
    if (cons_pc.size() >= 2) begin
      chk("t1_first_latency", 32'(cons_cyc[0] - t0), 32'd4);
      chk("t1_pc0", cons_pc[0], 32'h0);
      chk("t1_pc1", cons_pc[1], 32'h4);
      chk("t1_back_to_back", 32'(cons_cyc[1] - cons_cyc[0]), 32'd1);
    end

    // Two compressed instructions in one word
    mem.delete(); mem[32'h0] = 32'h0001_4501; mem[32'h4] = 32'h00A0_0113;
    do_reset(); clear_log(); RESET = 1'b1;
`ifdef FETCH_COMPRESSED_EN
    run_until_cons(3, 20, "t2_count");
    if (cons_pc.size() >= 3) begin
      chk("t2_raw0", cons_raw[0], 32'h0000_4501);
      chk("t2_pc1", cons_pc[1], 32'h2);
      chk("t2_raw1", cons_raw[1], 32'h0000_0001);
      chk("t2_pc2", cons_pc[2], 32'h4);
      chk("t2_raw2", cons_raw[2], 32'h00A0_0113);
    end
`else
    run_until_cons(2, 20, "t2_count");
    if (cons_pc.size() >= 2) begin
      chk("t2_raw0", cons_raw[0], 32'h0001_4501);
      chk("t2_pc1", cons_pc[1], 32'h4);
    end
`endif

    // Straddling 32-bit instruction with a slow second word
    mem.delete(); mem[32'h0] = 32'h0093_4501; mem[32'h4] = 32'hABCD_0050;
    slow_addr = 32'h4; slow_extra = 6;
    do_reset(); clear_log(); w1_seen = 0; early_cnt = 0; straddle_on = 1; RESET = 1'b1;
    run_until_cons(2, 40, "t3_count");
    if (cons_pc.size() >= 2) begin
`ifdef FETCH_COMPRESSED_EN
      chk("t3_pc1", cons_pc[1], 32'h2);
      chk("t3_raw1", cons_raw[1], 32'h0050_0093);
`else
      chk("t3_pc1", cons_pc[1], 32'h4);
      chk("t3_raw1", cons_raw[1], 32'hABCD_0050);
`endif
      chk("t3_gap", {31'b0, (cons_cyc[1] - cons_cyc[0]) > 3}, 32'h1);
    end
    chk("t3_early_valid", 32'(early_cnt), 32'h0);
    straddle_on = 0; slow_addr = 32'hFFFF_FFFF; slow_extra = 0;

    // Redirect with three responses in flight
    mem.delete(); seed = $urandom; lat = 3;
    do_reset(); RESET = 1'b1;
    n0 = 0;
    while (pend.size() != 3 && n0 < 30) begin tick(); n0++; end
    chk("t4_outstanding", 32'(pend.size()), 32'd3);
    clear_log(); REDIRECT = 1'b1; REDIRECT_PC = 32'h106;
    tick();
    chk("t4_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("t4_addr", IMEM_ADDRESS, 32'h104);
    run_until_cons(8, 60, "t4_count");
    if (cons_pc.size() >= 1) begin
`ifdef FETCH_COMPRESSED_EN
      chk("t4_first_pc", cons_pc[0], 32'h106);
`else
      chk("t4_first_pc", cons_pc[0], 32'h104);
`endif
    end

    // Decode stall: queue fills, requests stop, then drains without loss
    lat = 1; rdy_mode = 0;
    do_reset(); n_fire = 0; RESET = 1'b1;
    repeat (20) tick();
    chk("t5_fires", 32'(n_fire), 32'(DEPTH));
    chk("t5_req_low", {31'b0, IMEM_REQ}, 32'h0);
    chk("t5_valid_held", {31'b0, INSTR_VALID}, 32'h1);
    clear_log(); rdy_mode = 1; INSTR_READY = 1'b1;
    run_until_cons(12, 80, "t5_count");
    if (cons_pc.size() >= 1) chk("t5_first_pc", cons_pc[0], RESET_PC);

    // Reset mid-burst under random memory and decode timing
    lat_rand = 1; gnt_rand = 1; rdy_mode = 2;
    repeat (15) tick();
    RESET = 1'b0;
    tick();
    chk("t6_req_low", {31'b0, IMEM_REQ}, 32'h0);
    chk("t6_valid_low", {31'b0, INSTR_VALID}, 32'h0);
    RESET = 1'b1;
    tick();
    chk("t6_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("t6_addr", IMEM_ADDRESS, RESET_PC);

    // Random traffic with occasional redirects, some across the 2^32 wrap
    clear_log();
    repeat (800) begin
      if ($urandom_range(0, 29) == 0) begin
        REDIRECT = 1'b1;
        if ($urandom_range(0, 3) == 0) REDIRECT_PC = 32'hFFFF_FFF8 + 32'($urandom_range(0, 3) * 2);
        else                           REDIRECT_PC = 32'($urandom_range(0, 1023)) << 1;
      end
      tick();
    end
    chk("t7_progress", {31'b0, cons_pc.size() > 100}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_align_queue.md
# fetch_align_queue

Parametrised instruction-fetch front end that sits between instruction memory and the IF/ID pipeline register. It issues sequential word fetches through a request/grant/response handshake and buffers returned words in a DEPTH-entry queue. It realigns the buffered halfword stream into complete 16-bit (compressed) or 32-bit instructions, so the PC advances by 2 or 4 rather than a fixed 4. Redirects from the execute stage flush the queue and discard in-flight responses.

## Interface
Parameters:
- DEPTH, 4, queue depth in 32-bit words; power of two, ≥2
- RESET_PC, 32'h0, fetch address after reset

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-low reset
- IMEM_REQ  output  1  fetch request valid
- IMEM_ADDRESS  output  32  word-aligned fetch address, [1:0]=0
- IMEM_GNT  input  1  request accepted this cycle
- IMEM_RVALID  input  1  response valid; responses return in request order, ≥1 cycle after grant
- IMEM_READDATA  input  32  response word
- REDIRECT  input  1  taken branch/jump; flush and refetch
- REDIRECT_PC  input  32  new PC, halfword aligned
- INSTR_VALID  output  1  INSTR_* hold a complete instruction
- INSTR_READY  input  1  decode accepts (driven ~STALL)
- INSTR_RAW  output  32  instruction bits; compressed in [15:0], [31:16]=0
- INSTR_PC  output  32  PC of INSTR_RAW
- INSTR_COMPRESSED  output  1  INSTR_RAW[1:0] != 2'b11

## Operation
- State: fetch PC (word address), queue of {word, word address}, halfword head offset (0/1), outstanding counter (0..DEPTH), stale counter (0..DEPTH).
- Issue: IMEM_REQ=1 iff occupancy + outstanding < DEPTH and not in reset. On IMEM_REQ&IMEM_GNT: fetch PC += 4, outstanding++.
- Response: IMEM_RVALID with stale>0 → word dropped, stale--, outstanding--. Otherwise word pushed to tail, outstanding--. Simultaneous grant and response: net outstanding unchanged.
- Realign: head halfword h = offset ? head[31:16] : head[15:0].
  - h[1:0]!=11 → 16-bit instruction, valid when head present.
  - Otherwise 32-bit instruction, valid only when the upper halfword is available: same word if offset=0, else low half of the next entry.
- Consume (INSTR_VALID&INSTR_READY): advance by 1 or 2 halfwords. Pop every word fully consumed. INSTR_PC += 2 or 4, wrapping mod 2^32.
- Redirect (highest priority, overrides consume/push in that cycle):
  - Queue emptied.
  - stale ← outstanding − (IMEM_RVALID?1:0) + (IMEM_REQ&IMEM_GNT?1:0).
  - Fetch PC ← {REDIRECT_PC[31:2],2'b00}; offset ← REDIRECT_PC[1].
  - Head-PC ← REDIRECT_PC.
- Reset (RESET=0 at edge, any state, mid-transaction included):
  - Queue empty; outstanding=stale=0; fetch PC=RESET_PC; offset=0.
  - IMEM_REQ=0 and INSTR_VALID=0 while RESET=0.
  - Responses arriving after reset release are ignored until the first post-reset grant. The memory must be reset with the core.

## Timing
- IMEM_REQ and INSTR_* are combinational from registered state only. No input→output combinational path except none; REDIRECT takes effect at the edge.
- Redirect at edge N → IMEM_REQ with new address in cycle N+1. With 1-cycle memory: RVALID in N+2, INSTR_VALID in N+3 (3-cycle refill).
- Steady state with a single-cycle granting memory: one 32-bit or one 16-bit instruction per cycle, no bubbles.
- 32-bit instruction at offset 1 whose second word is not yet returned: INSTR_VALID=0 until that word is queued.
- Queue full: no request issued; INSTR_READY held 0 indefinitely loses nothing.

## Configuration
- FETCH_COMPRESSED_EN defined: halfword realignment as above.
- Undefined:
  - Offset is constant 0 and REDIRECT_PC[1] is ignored.
  - Every head word is issued as a 32-bit instruction; PC steps by 4.
  - INSTR_COMPRESSED is tied 0.
  - Straddle logic is removed.

## Structure
- Package fetch_pkg: XLEN=32, ILEN=32, HALF=16, RVC opcode-low constant 2'b11, queue entry struct {word, addr}.
- One sub-module: fetch_fifo, a synchronous DEPTH×64 FIFO with push/pop/flush. It exposes head and head+1 entries and occupancy.

## Test plan
- Reset release, RESET_PC=0, memory returns 32'h00500093 at 0 and 32'h00A00113 at 4 with 1-cycle latency → INSTR_PC 0 then 4, INSTR_COMPRESSED=0, one instruction per cycle.
- Word 0 = 32'h0001_4501 (two c.li/c.nop) → INSTR_RAW 32'h4501 at PC 0, 32'h0001 at PC 2, then the next instruction at PC 4.
- Straddle: word 0 = 32'h0093_4501, word 1 = 32'h????_0050 → second instruction 32'h00500093 at PC 2; INSTR_VALID low until word 1 returns.
- Redirect to 32'h106 while 3 responses are outstanding → those 3 dropped; next request address 32'h104; first INSTR_PC=32'h106.
- Hold INSTR_READY=0 → IMEM_REQ deasserts once occupancy+outstanding=DEPTH; release → stream resumes with no lost or duplicated PC.
- RESET=0 mid-burst → next edge IMEM_REQ=0 and INSTR_VALID=0; after release fetch restarts at RESET_PC.
